// File: rtl/ax_adder_pkg.sv
// Shared helpers for the approximate Ladner-Fischer adder.
//   pg_combine   : prefix operator on {g,p} pairs (hi group absorbs lo group)
//   lf_levels    : number of prefix levels for a given width
//   seg_level_lo : first prefix level evaluated by a pipeline segment
package ax_adder_pkg;

  // {g,p} o {g,p}: the hi group generates, or propagates the lo group's generate.
  function automatic logic [1:0] pg_combine(input logic [1:0] hi, input logic [1:0] lo);
    return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
  endfunction

  function automatic int lf_levels(input int width);
    return $clog2(width);
  endfunction

  // Segment s is the combinational logic feeding register rank s+1.
  // With one stage everything sits in segment 0. Otherwise segment 0 only
  // forms p/g and the levels are spread evenly over segments 1..stages-1.
  // Segment s evaluates levels [seg_level_lo(s), seg_level_lo(s+1)).
  function automatic int seg_level_lo(input int seg, input int stages, input int levels);
    if (seg <= 0)       return 0;
    if (seg >= stages)  return levels;
    return ((seg - 1) * levels) / (stages - 1);
  endfunction

endpackage

// File: rtl/ax_lf_prefix_tree.sv
// Combinational slice of a Ladner-Fischer (minimum-depth) prefix tree over
// bits LO..WIDTH-1. Only levels LV_LO..LV_HI-1 are evaluated here, so the top
// level can cut the tree between register ranks. With CI_EN the group
// carry-in is folded into bit LO first (g_LO |= p_LO & ci), after which the
// group generate at bit i equals the carry into bit i+1.
// Bits below LO pass through untouched.
//   g, p   : group generate/propagate entering this slice
//   ci     : group carry-in (used only when CI_EN)
//   g_o,p_o: group generate/propagate after this slice
module ax_lf_prefix_tree
  import ax_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LO    = 0,
  parameter int LV_LO = 0,
  parameter int LV_HI = lf_levels(WIDTH),
  parameter bit CI_EN = 1'b1
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic             ci,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  logic [WIDTH-1:0] gv, pv, gn, pn;
  logic [1:0]       r;

  always_comb begin
    gv = g;
    pv = p;
    gn = g;
    pn = p;
    r  = '0;
    if (CI_EN) gv[LO] = g[LO] | (p[LO] & ci);
    for (int l = LV_LO; l < LV_HI; l++) begin
      gn = gv;
      pn = pv;
      for (int i = LO; i < WIDTH; i++) begin
        // Nodes in the upper half of each 2^(l+1) block absorb the last
        // node of the lower half.
        if ((((i - LO) >> l) & 1) != 0) begin
          r = pg_combine({gv[i], pv[i]},
                         {gv[LO + ((((i - LO) >> l) << l) - 1)],
                          pv[LO + ((((i - LO) >> l) << l) - 1)]});
          gn[i] = r[1];
          pn[i] = r[0];
        end
      end
      gv = gn;
      pv = pn;
    end
    g_o = gv;
    p_o = pv;
  end

endmodule

// File: rtl/ax_lf_adder_pipe.sv
// Pipelined Ladner-Fischer adder with per-transaction approximate mode.
// Exact and approximate carries are computed side by side; the approximate
// path replaces carries into bits 1..K with g_{i-1} and runs an LF tree over
// bits K..WIDTH-1 seeded by c_K. out_err flags a differing {cout,sum}.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_a, in_b, in_cin, in_approx)
//   out_valid/out_ready : result handshake (out_sum, out_cout, out_err)
//   err_clr             : synchronous clear of err_cnt
//   err_cnt             : saturating count of delivered erroneous results
module ax_lf_adder_pipe
  import ax_adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int K           = 4,
  parameter int PIPE_STAGES = 2,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_cin,
  input  logic                 in_approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sum,
  output logic                 out_cout,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int LV = lf_levels(WIDTH);

  // lowc holds c_0..c_K of the approximate path (c_0 = cin, c_i = g_{i-1}).
  typedef struct packed {
    logic             mode;
    logic [K:0]       lowc;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] ge;
    logic [WIDTH-1:0] pe;
    logic [WIDTH-1:0] ga;
    logic [WIDTH-1:0] pa;
  } stage_t;

  logic                   adv;
  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES:0]   vld_pipe;

  // Whole pipe moves together; it only stalls when the output is held.
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[PIPE_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[PIPE_STAGES-1:0];
  end

  stage_t src0;

  always_comb begin
    src0      = '0;
    src0.mode = in_approx;
    src0.p    = in_a ^ in_b;
    src0.pe   = in_a ^ in_b;
    src0.pa   = in_a ^ in_b;
    src0.ge   = in_a & in_b;
    src0.ga   = in_a & in_b;
    src0.lowc[0] = in_cin;
    for (int i = 1; i <= K; i++) src0.lowc[i] = in_a[i-1] & in_b[i-1];
  end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_seg
    stage_t           din, dout;
    logic [WIDTH-1:0] ge_o, pe_o, ga_o, pa_o;

    if (s == 0) begin : g_src
      assign din = src0;
    end else begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   din <= '0;
        else if (adv) din <= g_seg[s-1].dout;
      end
    end

    ax_lf_prefix_tree #(
      .WIDTH(WIDTH), .LO(0),
      .LV_LO(seg_level_lo(s, PIPE_STAGES, LV)),
      .LV_HI(seg_level_lo(s + 1, PIPE_STAGES, LV)),
      .CI_EN(s == 0)
    ) u_exact (
      .g(din.ge), .p(din.pe), .ci(din.lowc[0]), .g_o(ge_o), .p_o(pe_o)
    );

    ax_lf_prefix_tree #(
      .WIDTH(WIDTH), .LO(K),
      .LV_LO(seg_level_lo(s, PIPE_STAGES, LV)),
      .LV_HI(seg_level_lo(s + 1, PIPE_STAGES, LV)),
      .CI_EN(s == 0)
    ) u_apx (
      .g(din.ga), .p(din.pa), .ci(din.lowc[K]), .g_o(ga_o), .p_o(pa_o)
    );

    always_comb begin
      dout    = din;
      dout.ge = ge_o;
      dout.pe = pe_o;
      dout.ga = ga_o;
      dout.pa = pa_o;
    end
  end

  stage_t           fin;
  logic [WIDTH:0]   ce, ca;
  logic [WIDTH-1:0] sum_nx;
  logic             cout_nx, err_nx;
  logic             unused_pp;

  assign fin       = g_seg[PIPE_STAGES-1].dout;
  // Final group propagates are not needed once carries are resolved.
  assign unused_pp = ^{fin.pe, fin.pa};

  always_comb begin
    ce      = {fin.ge, fin.lowc[0]};
    ca      = {fin.ga, fin.lowc[0]};
    ca[K:0] = fin.lowc;
    sum_nx  = fin.p ^ (fin.mode ? ca[WIDTH-1:0] : ce[WIDTH-1:0]);
    cout_nx = fin.mode ? ca[WIDTH] : ce[WIDTH];
    // Same p on both paths, so {cout,sum} differ exactly when carries differ.
    err_nx  = fin.mode & (ca != ce);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_err  <= 1'b0;
    end else if (adv) begin
      out_sum  <= sum_nx;
      out_cout <= cout_nx;
      out_err  <= err_nx;
    end
  end

  // Clear has priority over a coincident counted delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (out_valid && out_ready && out_err && (err_cnt != '1))
      err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_ax_lf_adder_pipe.sv
// Scoreboard bench for ax_lf_adder_pipe (WIDTH=16, K=4, 2 stages, 2-bit
// error counter). Stimulus pushes hand-computed results; the monitor pops
// and compares on every delivered output.
module tb_ax_lf_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic        in_cin, in_approx;
  logic        out_valid, out_ready;
  logic [15:0] out_sum;
  logic        out_cout, out_err;
  logic        err_clr;
  logic [1:0]  err_cnt;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ax_lf_adder_pipe #(.WIDTH(16), .K(4), .PIPE_STAGES(2), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_approx(in_approx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: values are stable half a cycle before the edge that delivers them.
  always @(negedge clk) begin : mon
    exp_t e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected output", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("result {err,cout,sum}", {14'd0, out_err, out_cout, out_sum},
              {14'd0, e.err, e.cout, e.sum});
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic ap, input logic [15:0] es, input logic ec, input logic ee);
    int   t;
    exp_t x;
    in_a = a; in_b = b; in_cin = cin; in_approx = ap; in_valid = 1'b1;
    #1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready) begin
      check("in_ready timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    x.sum = es; x.cout = ec; x.err = ee;
    q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk); #1; t++;
    end
    check("drain pending results", q.size(), 32'd0);
    @(negedge clk); #1;
  endtask

  initial begin : stim
    logic [17:0] hold;
    int          t;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_approx = 1'b0; out_ready = 1'b1; err_clr = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_sum", out_sum, 0);
    check("reset out_cout/err", {out_cout, out_err}, 0);
    check("reset err_cnt", err_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("in_ready after reset", in_ready, 1);

    // No carries at all: both paths agree; latency exactly 2 cycles.
    @(negedge clk);
    send(16'h1234, 16'h0101, 1'b0, 1'b1, 16'h1335, 1'b0, 1'b0);
    #1;
    check("latency: not valid after 1 cycle", out_valid, 0);
    @(negedge clk); #1;
    check("latency: valid after 2 cycles", out_valid, 1);
    drain();

    // Carry out of bit 3 lost in approximate mode, then exact.
    send(16'h000F, 16'h0001, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b1);
    drain();
    check("err_cnt after first error", err_cnt, 1);
    send(16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
    drain();
    check("err_cnt unchanged by exact", err_cnt, 1);

    // Full ripple, mode toggled back to back; cin handling.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
    send(16'h00F0, 16'h0010, 1'b1, 1'b1, 16'h0101, 1'b0, 1'b0);
    drain();
    check("err_cnt after ripple", err_cnt, 2);

    // Backpressure: fill the pipe with out_ready low, third operand waits.
    out_ready = 1'b0;
    send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    in_a = 16'h8000; in_b = 16'h8000; in_cin = 1'b1; in_approx = 1'b0; in_valid = 1'b1;
    #1;
    check("in_ready low when full", in_ready, 0);
    check("stalled out_valid", out_valid, 1);
    check("stalled head sum", out_sum, 16'h0003);
    hold = {out_err, out_cout, out_sum};
    repeat (3) begin
      @(negedge clk); #1;
      check("held output stable", {out_valid, out_err, out_cout, out_sum}, {1'b1, hold});
      check("in_ready held low", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    send(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
    drain();

    // Saturation of the 2-bit counter.
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1;
    check("err_cnt cleared", err_cnt, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      send(16'h000F, 16'h0001, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b1);
    drain();
    check("err_cnt saturated", err_cnt, 3);

    // Clear coincident with an erroring delivery: clear wins.
    send(16'h000F, 16'h0001, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b1);
    #1;
    t = 0;
    while (!out_valid && t < 10) begin
      @(negedge clk); #1; t++;
    end
    check("erroring result presented", out_valid, 1);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1;
    check("clear wins over count", err_cnt, 0);
    @(negedge clk);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b1);
    drain();
    check("counting resumes after clear", err_cnt, 1);

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    send(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    send(16'h0010, 16'h0020, 1'b0, 1'b1, 16'h0030, 1'b0, 1'b0);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("out_valid drops in reset", out_valid, 0);
    check("out_sum cleared in reset", out_sum, 0);
    check("err_cnt cleared in reset", err_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      check("no output after reset release", out_valid, 0);
    end

    check("scoreboard empty at end", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog timeout");
  end

endmodule
